// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit accumulator CPU: widths, ALU op indices, op vector.
package cpu19_pkg;

  localparam int unsigned WORD_W   = 19;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned OP_N     = 14;
  localparam int unsigned OP_IDX_W = 4;

  // ALU operation index, listed in strobe priority order (highest first)
  typedef enum logic [OP_IDX_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_FFT = 4'd10,
    OP_ENC = 4'd11,
    OP_DNC = 4'd12,
    OP_TNF = 4'd13
  } op_idx_e;

  // One bit per operation strobe, bit position equals op_idx_e value
  typedef logic [OP_N-1:0] op_vec_t;

endpackage

// File: rtl/cpu19_alu_core.sv
// Combinational ALU datapath: result and overflow for one selected operation.
module cpu19_alu_core
  import cpu19_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] ac_i,
  input  logic [WIDTH-1:0] dr_i,
  input  op_idx_e          op_i,
  output logic [WIDTH-1:0] res_c_o,
  output logic             ovf_c_o
);

  localparam int unsigned EXT_W  = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  logic [EXT_W-1:0]  sum;
  logic [EXT_W-1:0]  diff;
  logic [PROD_W-1:0] prod;
  logic [WIDTH-1:0]  divisor;
  logic [WIDTH-1:0]  quot;
  logic [WIDTH-1:0]  rev;
  logic [WIDTH-1:0]  mix;
  logic              dr_zero;

  // Top bit of the extended sum is the carry; of the extended difference, the borrow
  assign sum     = EXT_W'(ac_i) + EXT_W'(dr_i);
  assign diff    = EXT_W'(ac_i) - EXT_W'(dr_i);
  assign prod    = PROD_W'(ac_i) * PROD_W'(dr_i);
  // Substitute a divisor of 1 so the divider never sees zero; result is overridden below
  assign dr_zero = (dr_i == '0);
  assign divisor = dr_zero ? WIDTH'(1) : dr_i;
  assign quot    = ac_i / divisor;
  assign mix     = ac_i ^ dr_i;

  // Bit-reverse of AC
  always_comb begin
    rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rev[i] = ac_i[int'(WIDTH) - 1 - i];
    end
  end

  // Operation select
  always_comb begin
    res_c_o = '0;
    ovf_c_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_c_o = sum[WIDTH-1:0];
        ovf_c_o = sum[WIDTH];
      end
      OP_SUB: begin
        res_c_o = diff[WIDTH-1:0];
        ovf_c_o = diff[WIDTH];
      end
      OP_MUL: begin
        res_c_o = prod[WIDTH-1:0];
        ovf_c_o = |prod[PROD_W-1:WIDTH];
      end
      OP_DIV: begin
        res_c_o = dr_zero ? '1 : quot;
        ovf_c_o = dr_zero;
      end
      OP_AND: res_c_o = ac_i & dr_i;
      OP_OR:  res_c_o = ac_i | dr_i;
      OP_XOR: res_c_o = mix;
      OP_NOT: res_c_o = ~ac_i;
      OP_INC: begin
        res_c_o = ac_i + WIDTH'(1);
        ovf_c_o = &ac_i;
      end
      OP_DEC: begin
        res_c_o = ac_i - WIDTH'(1);
        ovf_c_o = ~|ac_i;
      end
      OP_FFT: res_c_o = rev;
      // Encrypt: rotate left by one after mixing with DR
      OP_ENC: res_c_o = {mix[WIDTH-2:0], mix[WIDTH-1]};
      // Decrypt: undo the rotate first, then unmix with DR
      OP_DNC: res_c_o = {ac_i[0], ac_i[WIDTH-1:1]} ^ dr_i;
      OP_TNF: res_c_o = dr_i;
      default: begin
        res_c_o = '0;
        ovf_c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu19_alu_unit.sv
// Registered ALU: priority-selects one op strobe, holds when idle, sync clear.
module cpu19_alu_unit
  import cpu19_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] AC,
  input  logic [WIDTH-1:0] DR,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             MUL,
  input  logic             DIV,
  input  logic             AND,
  input  logic             OR,
  input  logic             XOR,
  input  logic             NOT,
  input  logic             INC,
  input  logic             DEC,
  input  logic             FFT,
  input  logic             ENC,
  input  logic             DNC,
  input  logic             TNF,
  output logic [WIDTH-1:0] ALU_OP,
  output logic             OVF_FLAG
);

  op_vec_t          op_vec;
  op_idx_e          op_sel;
  logic             any_op;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic [WIDTH-1:0] alu_op_q;
  logic             ovf_q;

  assign op_vec = {TNF, DNC, ENC, FFT, DEC, INC, NOT, XOR, OR, AND, DIV, MUL, SUB, ADD};
  assign any_op = |op_vec;

  // Priority encoder: lowest set bit (ADD side) wins
  always_comb begin
    op_sel = OP_ADD;
    for (int i = int'(OP_N) - 1; i >= 0; i--) begin
      if (op_vec[i]) begin
        op_sel = op_idx_e'(OP_IDX_W'(i));
      end
    end
  end

  cpu19_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .ac_i    (AC),
    .dr_i    (DR),
    .op_i    (op_sel),
    .res_c_o (res_d),
    .ovf_c_o (ovf_d)
  );

  // Output registers: clear dominates, load on any strobe, otherwise hold
  always_ff @(posedge CLK) begin
    if (CLR) begin
      alu_op_q <= '0;
      ovf_q    <= 1'b0;
    end else if (any_op) begin
      alu_op_q <= res_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ALU_OP   = alu_op_q;
  assign OVF_FLAG = ovf_q;

endmodule

// File: tb/tb_cpu19_alu_unit.sv
// Self-checking bench for cpu19_alu_unit: directed table, hand sequences, random vs model.
module tb_cpu19_alu_unit;

  localparam int W = 19;
  localparam longint MOD = 64'd1 << W;
  localparam longint MSK = MOD - 1;

  logic          CLK = 1'b0;
  logic          CLR;
  logic [W-1:0]  AC, DR;
  logic [13:0]   ops;
  logic [W-1:0]  ALU_OP;
  logic          OVF_FLAG;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cpu19_alu_unit dut (
    .CLK(CLK), .CLR(CLR), .AC(AC), .DR(DR),
    .ADD(ops[0]), .SUB(ops[1]), .MUL(ops[2]), .DIV(ops[3]),
    .AND(ops[4]), .OR(ops[5]), .XOR(ops[6]), .NOT(ops[7]),
    .INC(ops[8]), .DEC(ops[9]), .FFT(ops[10]), .ENC(ops[11]),
    .DNC(ops[12]), .TNF(ops[13]),
    .ALU_OP(ALU_OP), .OVF_FLAG(OVF_FLAG)
  );

  typedef struct {
    logic [13:0]  ops;
    logic [W-1:0] ac;
    logic [W-1:0] dr;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t tv[$];

  // Reference model state
  logic [W-1:0] m_res;
  logic         m_ovf;

  function automatic vec_t mk(int op, logic [W-1:0] a, logic [W-1:0] d,
                              logic [W-1:0] r, logic o);
    vec_t v;
    v.ops = 14'd0;
    v.ops[op] = 1'b1;
    v.ac = a; v.dr = d; v.res = r; v.ovf = o;
    return v;
  endfunction

  // Behavioural result of one op, straight from the arithmetic definitions
  task automatic ref_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] d,
                        output logic [W-1:0] r, output logic o);
    longint la, ld, t;
    la = longint'(a);
    ld = longint'(d);
    t = 0;
    o = 1'b0;
    case (idx)
      0: begin t = la + ld;  o = (t >= MOD); end
      1: begin t = la - ld;  o = (la < ld); if (t < 0) t = t + MOD; end
      2: begin t = la * ld;  o = (t >= MOD); end
      3: begin if (ld == 0) begin t = MSK; o = 1'b1; end else t = la / ld; end
      4: t = la & ld;
      5: t = la | ld;
      6: t = la ^ ld;
      7: t = MSK - la;
      8: begin t = la + 1; o = (la == MSK); end
      9: begin t = (la == 0) ? MSK : la - 1; o = (la == 0); end
      10: begin
        t = 0;
        for (int i = 0; i < W; i++) if (((la >> i) & 1) != 0) t = t | (64'd1 << (W - 1 - i));
      end
      11: begin t = la ^ ld; t = ((t * 2) % MOD) + (t / (MOD / 2)); end
      12: t = ((la / 2) + ((la % 2) * (MOD / 2))) ^ ld;
      default: t = ld;
    endcase
    r = W'(t % MOD);
  endtask

  task automatic model_step(input logic clr, input logic [13:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] d);
    int win;
    win = -1;
    for (int i = 13; i >= 0; i--) if (o[i]) win = i;
    if (clr) begin
      m_res = '0; m_ovf = 1'b0;
    end else if (win >= 0) begin
      ref_op(win, a, d, m_res, m_ovf);
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] er, input logic eo);
    checks++;
    if (ALU_OP !== er || OVF_FLAG !== eo) begin
      errors++;
      $display("FAIL %s: got ALU_OP=%h OVF=%b, want ALU_OP=%h OVF=%b", nm, ALU_OP, OVF_FLAG, er, eo);
    end
  endtask

  // Drive inputs, take one rising edge, settle past it
  task automatic cyc(input logic clr, input logic [13:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] d);
    CLR = clr; ops = o; AC = a; DR = d;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return '0;
    if (s == 1) return '1;
    if (s == 2) return W'($urandom_range(0, 15));
    return W'($urandom);
  endfunction

  initial begin
    CLR = 1'b1; ops = '0; AC = '0; DR = '0;
    m_res = '0; m_ovf = 1'b0;
    #1;

    // Reset dominance, then first real op
    cyc(1'b1, 14'h0001, 19'd5, 19'd3);
    chk("reset_dominance", 19'd0, 1'b0);
    cyc(1'b0, 14'h0001, 19'd5, 19'd3);
    chk("add_after_reset", 19'd8, 1'b0);

    // Directed single-op vectors with hand-derived expectations
    tv.push_back(mk(0,  19'h7FFFF, 19'd1,     19'd0,     1'b1));
    tv.push_back(mk(1,  19'd3,     19'd5,     19'h7FFFE, 1'b1));
    tv.push_back(mk(1,  19'd5,     19'd3,     19'd2,     1'b0));
    tv.push_back(mk(2,  19'd300,   19'd4,     19'd1200,  1'b0));
    tv.push_back(mk(2,  19'd1024,  19'd1024,  19'd0,     1'b1));
    tv.push_back(mk(3,  19'd100,   19'd7,     19'd14,    1'b0));
    tv.push_back(mk(3,  19'd9,     19'd0,     19'h7FFFF, 1'b1));
    tv.push_back(mk(4,  19'h0FF0F, 19'h3C3C3, 19'h0C303, 1'b0));
    tv.push_back(mk(5,  19'h0FF0F, 19'h30000, 19'h3FF0F, 1'b0));
    tv.push_back(mk(6,  19'h7FFFF, 19'h2AAAA, 19'h55555, 1'b0));
    tv.push_back(mk(7,  19'd0,     19'd0,     19'h7FFFF, 1'b0));
    tv.push_back(mk(10, 19'h00001, 19'd0,     19'h40000, 1'b0));
    tv.push_back(mk(8,  19'h7FFFF, 19'd0,     19'd0,     1'b1));
    tv.push_back(mk(9,  19'd0,     19'd0,     19'h7FFFF, 1'b1));
    tv.push_back(mk(8,  19'd41,    19'd0,     19'd42,    1'b0));
    tv.push_back(mk(13, 19'd7,     19'h2AAAA, 19'h2AAAA, 1'b0));
    tv.push_back(mk(11, 19'h12345, 19'h0F0F0, 19'h3A76A, 1'b0));
    tv.push_back(mk(12, 19'h3A76A, 19'h0F0F0, 19'h12345, 1'b0));

    foreach (tv[k]) begin
      cyc(1'b0, tv[k].ops, tv[k].ac, tv[k].dr);
      chk($sformatf("vec%0d", k), tv[k].res, tv[k].ovf);
    end

    // Overflow set, then a non-overflowing op must clear it
    cyc(1'b0, 14'h0001, 19'h7FFFF, 19'd2);
    chk("ovf_set", 19'd1, 1'b1);
    cyc(1'b0, 14'h0010, 19'h7FFFF, 19'd2);
    chk("ovf_cleared", 19'd2, 1'b0);

    // Priority and hold
    cyc(1'b0, 14'h0003, 19'd5, 19'd3);
    chk("prio_add_over_sub", 19'd8, 1'b0);
    cyc(1'b0, 14'h0000, 19'd77, 19'd99);
    chk("hold_idle", 19'd8, 1'b0);
    cyc(1'b0, 14'h2008, 19'd9, 19'd0);
    chk("prio_div_over_tnf", 19'h7FFFF, 1'b1);
    cyc(1'b0, 14'h0000, 19'd1, 19'd1);
    chk("hold_ovf", 19'h7FFFF, 1'b1);
    cyc(1'b0, 14'h3000, 19'h3A76A, 19'h0F0F0);
    chk("prio_dnc_over_tnf", 19'h12345, 1'b0);

    // Randomized traffic against the model
    CLR = 1'b1; ops = '0; @(posedge CLK); #1;
    m_res = '0; m_ovf = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic         c;
      logic [13:0]  o;
      logic [W-1:0] a, d;
      int           s;
      c = ($urandom_range(0, 24) == 0);
      s = $urandom_range(0, 9);
      if (s == 0) o = '0;
      else if (s <= 2) o = 14'($urandom);
      else begin
        o = '0;
        o[$urandom_range(0, 13)] = 1'b1;
      end
      a = rnd_word();
      d = rnd_word();
      model_step(c, o, a, d);
      cyc(c, o, a, d);
      chk($sformatf("rand%0d", n), m_res, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu19_alu_unit.md
Name: cpu19_alu_unit

Overview:
- Registered 19-bit arithmetic/logic unit of the 19-bit accumulator CPU.
- Combines the accumulator (AC) and data register (DR) operands under one-hot operation strobes from the control unit.
- Produces a registered result that feeds the AC load input, plus an overflow flag.
- One clock of latency: control asserts an op strobe in cycle Tn and loads AC in cycle Tn+1.

Parameters:
- WIDTH, 19, datapath width. All rotates, masks and overflow limits are derived from it. Only 19 is verified.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- CLR  in  1  synchronous active-high reset.
- AC  in  WIDTH  operand A (accumulator).
- DR  in  WIDTH  operand B (data register).
- ADD, SUB, MUL, DIV, AND, OR, XOR, NOT, INC, DEC, FFT, ENC, DNC, TNF  in  1 each  operation strobes, intended one-hot.
- ALU_OP  out  WIDTH  registered result.
- OVF_FLAG  out  1  registered overflow/error flag.

Behaviour:
- Reset: CLR=1 at a rising edge forces ALU_OP=0 and OVF_FLAG=0. Reset overrides any strobe in the same cycle.
- Update rule: at a rising edge with CLR=0 and at least one strobe high, both outputs load the selected result.
- Hold rule: with no strobe high, both outputs hold their previous values.
- Priority when several strobes are high, highest first: ADD, SUB, MUL, DIV, AND, OR, XOR, NOT, INC, DEC, FFT, ENC, DNC, TNF. Only the winner takes effect.
- All arithmetic is unsigned and modulo 2^WIDTH.
- ADD: AC+DR. OVF = carry out of bit WIDTH-1.
- SUB: AC-DR. OVF = borrow (AC<DR).
- MUL: low WIDTH bits of AC*DR. OVF = 1 if any bit of the upper WIDTH bits of the full product is nonzero.
- DIV: floor(AC/DR), OVF=0. If DR=0, result is all ones (19'h7FFFF) and OVF=1.
- AND, OR, XOR: bitwise AC op DR. NOT: ~AC. OVF=0 for all four.
- INC: AC+1, OVF=1 only when AC=all ones (result then 0).
- DEC: AC-1, OVF=1 only when AC=0 (result then all ones).
- FFT: bit-reverse of AC, i.e. result[i]=AC[WIDTH-1-i]. OVF=0.
- ENC: rotate-left-by-1 of (AC XOR DR) within WIDTH bits. OVF=0.
- DNC: (rotate-right-by-1 of AC) XOR DR. It is the exact inverse of ENC for the same DR. OVF=0.
- TNF: transfer DR to the result unchanged. OVF=0.
- OVF_FLAG is written on every executed op, so a non-overflowing op clears it.
- No X propagation: operand inputs are fully used; unused product/quotient bits are discarded.

Decomposition:
- Shared package cpu19_pkg:
  - WORD_W=19 and ADDR_W=12.
  - An op-index enum (ADD..TNF, 14 entries) in the priority order above.
  - A 14-bit op-vector typedef.
- Natural sub-module: cpu19_alu_core, fully combinational. It computes the result and overflow from AC, DR and the selected op index.
- The top level owns the priority encoder, the output registers, reset and hold.

Test Plan:
- Reset dominance: CLR=1, ADD=1, AC=5, DR=3 -> after the edge ALU_OP=0, OVF_FLAG=0. Next edge with CLR=0 and ADD=1 -> ALU_OP=8, OVF=0.
- ADD/SUB boundaries:
  - ADD 19'h7FFFF+1 -> 0, OVF=1.
  - SUB 3-5 -> 19'h7FFFE, OVF=1.
  - SUB 5-3 -> 2, OVF=0.
- MUL/DIV:
  - MUL 300*4 -> 1200, OVF=0.
  - MUL 1024*1024 -> 0, OVF=1.
  - DIV 100/7 -> 14, OVF=0.
  - DIV 9/0 -> 19'h7FFFF, OVF=1.
- Logic/unary:
  - NOT 0 -> 19'h7FFFF.
  - FFT 19'h00001 -> 19'h40000.
  - INC 19'h7FFFF -> 0, OVF=1.
  - DEC 0 -> 19'h7FFFF, OVF=1.
  - TNF with DR=19'h2AAAA -> 19'h2AAAA.
- Cipher round trip:
  - ENC with AC=19'h12345, DR=19'h0F0F0 -> 19'h3A76A.
  - Then DNC with AC=19'h3A76A, same DR -> 19'h12345.
- Priority/hold:
  - ADD and SUB both high, AC=5, DR=3 -> 8.
  - Next cycle no strobes with AC and DR changed -> ALU_OP stays 8 and OVF unchanged.
